// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked stimulus sequencer for a 3-input combinational gate.
// Steps {a,b,c} through 000..111, holds each vector for SETTLE cycles, then
// samples y against EXP_TT and accumulates per-vector failures.
//
// Control protocol: start and abort are level inputs sampled on each rising
// edge. start is acted on only in IDLE (and then wins over abort). abort is
// acted on only in DRIVE/SAMPLE. There is no back-pressure; done is a
// one-cycle pulse with no acknowledge.
module gate_sweep_ctrl #(
  parameter int          SETTLE = 5,      // legal 1..15
  parameter logic [7:0]  EXP_TT = 8'hFE   // bit i = expected y for {a,b,c} == i
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // state is kept as a named register so checkers can bind to it directly
  state_t     state, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // y compared against the expected truth-table bit of the current vector
  always_comb begin
    mismatch = (y != EXP_TT[vec_q]);
  end

  // next-state and datapath updates; every variable defaults to hold
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = 4'd0;
          vec_d   = 3'd0;
          err_d   = 4'd0;
          fail_d  = 8'h00;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = 3'd0;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          // the compare of this cycle is dropped; partial results are kept
          state_d = IDLE;
          vec_d   = 3'd0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_q + 4'd1;
          end
          if (vec_q == 3'd7) begin
            // pass is settled on entry to DONE so it is valid with the done pulse
            state_d = DONE;
            vec_d   = 3'd0;
            pass_d  = (err_d == 4'd0);
          end else begin
            state_d = DRIVE;
            vec_d   = vec_q + 3'd1;
            cnt_d   = 4'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= 4'd0;
      vec_q  <= 3'd0;
      err_q  <= 4'd0;
      fail_q <= 8'h00;
      pass_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end

  // outputs are decoded only from registers, never from inputs
  always_comb begin
    vec_idx  = vec_q;
    {a, b, c} = vec_q;
    busy     = (state == DRIVE) || (state == SAMPLE);
    done     = (state == DONE);
    pass     = pass_q;
    err_cnt  = err_q;
    fail_vec = fail_q;
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (default OR table, and an AND table
// with a shorter settle time), a truth-table gate model on y, and a reference
// model that derives results from gate table XOR expected table.
module tb_gate_sweep_ctrl;

  localparam int         S1  = 5;
  localparam logic [7:0] TT1 = 8'hFE;
  localparam int         S2  = 3;
  localparam logic [7:0] TT2 = 8'h80;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance 1 signals
  logic       start, abort, y;
  logic       a, b, c, busy, done, pass;
  logic [2:0] vec_idx;
  logic [3:0] err_cnt;
  logic [7:0] fail_vec;
  logic [7:0] gate_tt;

  // instance 2 signals
  logic       start2, abort2, y2;
  logic       a2, b2, c2, busy2, done2, pass2;
  logic [2:0] vec_idx2;
  logic [3:0] err_cnt2;
  logic [7:0] fail_vec2;
  logic [7:0] gate2_tt;

  int checks = 0;
  int errors = 0;

  // gate under test modelled as a truth table indexed by {a,b,c}
  assign y  = gate_tt[{a, b, c}];
  assign y2 = gate2_tt[{a2, b2, c2}];

  gate_sweep_ctrl #(.SETTLE(S1), .EXP_TT(TT1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y(y),
    .a(a), .b(b), .c(c), .vec_idx(vec_idx), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  gate_sweep_ctrl #(.SETTLE(S2), .EXP_TT(TT2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .y(y2),
    .a(a2), .b(b2), .c(c2), .vec_idx(vec_idx2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .fail_vec(fail_vec2)
  );

  // reference model: a vector fails when the gate disagrees with the table
  function automatic logic [7:0] model_fail(input logic [7:0] g, input logic [7:0] e,
                                            input logic [7:0] mask);
    return (g ^ e) & mask;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // driver: advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: start a sweep on instance 1 and watch it; counts cycles where
  // {a,b,c} or busy deviate from the expected stepping
  task automatic sweep(input int mid_k, input bit hold, output int done_k, output int bad);
    int per = S1 + 1;
    int last = 8 * per;
    start  = 1'b1;
    done_k = -1;
    bad    = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      start = hold ? 1'b1 : (k == mid_k);
      if (done === 1'b1) begin
        done_k = k;
        if (busy !== 1'b0 || vec_idx !== 3'd0) bad++;
        break;
      end
      if (k <= last && ({a, b, c} !== 3'((k - 1) / per) || busy !== 1'b1)) bad++;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    start = 0; abort = 0; start2 = 0; abort2 = 0;
    gate_tt = 8'h00; gate2_tt = 8'h00;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a, b, c, vec_idx, busy, done, pass, err_cnt, fail_vec} !== 21'd0) begin
      errors++;
      $display("FAIL reset_vals1 got %h want 0",
               {a, b, c, vec_idx, busy, done, pass, err_cnt, fail_vec});
    end
    checks++;
    if ({a2, b2, c2, vec_idx2, busy2, done2, pass2, err_cnt2, fail_vec2} !== 21'd0) begin
      errors++;
      $display("FAIL reset_vals2 got %h want 0",
               {a2, b2, c2, vec_idx2, busy2, done2, pass2, err_cnt2, fail_vec2});
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || {a, b, c} !== 3'b000 || busy2 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet bad_cycles %0d want 0", bad);
    end
  endtask

  task automatic test_or_model();
    int dk, bad;
    logic [7:0] ef;
    gate_tt = 8'hFE;
    ef = model_fail(gate_tt, TT1, 8'hFF);
    sweep(0, 1'b0, dk, bad);
    checks++;
    if (dk !== 1 + 8 * (S1 + 1)) begin errors++; $display("FAIL or_done_cycle got %0d want %0d", dk, 1 + 8 * (S1 + 1)); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL or_stepping bad_cycles %0d want 0", bad); end
    checks++;
    if ({pass, err_cnt, fail_vec} !== {popcount(ef) == 4'd0, popcount(ef), ef}) begin
      errors++;
      $display("FAIL or_result got pass=%b err=%0d fail=%h want pass=1 err=0 fail=00", pass, err_cnt, fail_vec);
    end
    tick(); tick(); tick();
    checks++;
    if ({pass, err_cnt, fail_vec, busy} !== {1'b1, 4'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL or_hold got pass=%b err=%0d fail=%h busy=%b", pass, err_cnt, fail_vec, busy);
    end
  endtask

  task automatic test_stuck0();
    int dk, bad;
    logic [7:0] ef;
    gate_tt = 8'h00;
    ef = model_fail(gate_tt, TT1, 8'hFF);
    sweep(0, 1'b0, dk, bad);
    checks++;
    if (dk !== 1 + 8 * (S1 + 1) || bad !== 0) begin
      errors++;
      $display("FAIL stuck0_timing done_cycle=%0d bad=%0d want %0d/0", dk, bad, 1 + 8 * (S1 + 1));
    end
    checks++;
    if ({pass, err_cnt, fail_vec} !== {1'b0, popcount(ef), ef}) begin
      errors++;
      $display("FAIL stuck0_result got pass=%b err=%0d fail=%h want pass=0 err=%0d fail=%h",
               pass, err_cnt, fail_vec, popcount(ef), ef);
    end
    tick();
  endtask

  task automatic test_and_model();
    int dk, bad;
    int dk2 = -1;
    logic [7:0] ef;
    gate_tt = 8'h80;
    ef = model_fail(gate_tt, TT1, 8'hFF);
    sweep(0, 1'b0, dk, bad);
    checks++;
    if ({pass, err_cnt, fail_vec} !== {1'b0, popcount(ef), ef}) begin
      errors++;
      $display("FAIL and_vs_or_result got pass=%b err=%0d fail=%h want pass=0 err=%0d fail=%h",
               pass, err_cnt, fail_vec, popcount(ef), ef);
    end
    tick();
    gate2_tt = 8'h80;
    start2 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      start2 = 1'b0;
      if (done2 === 1'b1) begin dk2 = k; break; end
    end
    checks++;
    if (dk2 !== 1 + 8 * (S2 + 1)) begin errors++; $display("FAIL and_done_cycle got %0d want %0d", dk2, 1 + 8 * (S2 + 1)); end
    checks++;
    if ({pass2, err_cnt2, fail_vec2} !== {1'b1, 4'd0, 8'h00}) begin
      errors++;
      $display("FAIL and_match_result got pass=%b err=%0d fail=%h want pass=1 err=0 fail=00", pass2, err_cnt2, fail_vec2);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dk, bad;
    gate_tt = 8'hFE;
    sweep(20, 1'b0, dk, bad);
    checks++;
    if (dk !== 1 + 8 * (S1 + 1) || bad !== 0) begin
      errors++;
      $display("FAIL mid_start done_cycle=%0d bad=%0d want %0d/0", dk, bad, 1 + 8 * (S1 + 1));
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_start_not_queued busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int dk, bad;
    gate_tt = 8'hFE;
    sweep(0, 1'b1, dk, bad);
    checks++;
    if (dk !== 1 + 8 * (S1 + 1) || bad !== 0) begin
      errors++;
      $display("FAIL b2b_first done_cycle=%0d bad=%0d", dk, bad);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap busy=%b want 0", busy); end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || {a, b, c} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_restart busy=%b abc=%b want 1/000", busy, {a, b, c});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int seen_done = 0;
    logic [7:0] ef;
    gate_tt = 8'h00;
    ef = model_fail(gate_tt, TT1, 8'h0F);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (vec_idx !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre vec=%0d busy=%b want 4/1", vec_idx, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, pass, vec_idx} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b pass=%b vec=%0d want 0/0/0/0", busy, done, pass, vec_idx);
    end
    checks++;
    if ({err_cnt, fail_vec} !== {popcount(ef), ef}) begin
      errors++;
      $display("FAIL abort_partial err=%0d fail=%h want err=%0d fail=%h", err_cnt, fail_vec, popcount(ef), ef);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL abort_quiet cycles %0d want 0", seen_done); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || err_cnt !== 4'd0 || fail_vec !== 8'h00) begin
      errors++;
      $display("FAIL start_wins busy=%b err=%0d fail=%h want 1/0/00", busy, err_cnt, fail_vec);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int dk, bad;
    int dk2;
    logic [7:0] ef;
    for (int it = 0; it < 6; it++) begin
      gate_tt = 8'($urandom_range(0, 255));
      ef = model_fail(gate_tt, TT1, 8'hFF);
      sweep(0, 1'b0, dk, bad);
      checks++;
      if (dk !== 1 + 8 * (S1 + 1) || bad !== 0 ||
          {pass, err_cnt, fail_vec} !== {popcount(ef) == 4'd0, popcount(ef), ef}) begin
        errors++;
        $display("FAIL rand1 tt=%h done_cycle=%0d bad=%0d got pass=%b err=%0d fail=%h want err=%0d fail=%h",
                 gate_tt, dk, bad, pass, err_cnt, fail_vec, popcount(ef), ef);
      end
      tick();
    end
    for (int it = 0; it < 4; it++) begin
      gate2_tt = (it == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      ef = model_fail(gate2_tt, TT2, 8'hFF);
      dk2 = -1;
      start2 = 1'b1;
      for (int k = 1; k <= 100; k++) begin
        tick();
        start2 = 1'b0;
        if (done2 === 1'b1) begin dk2 = k; break; end
      end
      checks++;
      if (dk2 !== 1 + 8 * (S2 + 1) ||
          {pass2, err_cnt2, fail_vec2} !== {popcount(ef) == 4'd0, popcount(ef), ef}) begin
        errors++;
        $display("FAIL rand2 tt=%h done_cycle=%0d got pass=%b err=%0d fail=%h want err=%0d fail=%h",
                 gate2_tt, dk2, pass2, err_cnt2, fail_vec2, popcount(ef), ef);
      end
      tick();
    end
  endtask

  task automatic test_async_reset_mid();
    int bad = 0;
    gate_tt = 8'h00;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (vec_idx !== 3'd3) begin errors++; $display("FAIL arst_pre vec=%0d want 3", vec_idx); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a, b, c, vec_idx, busy, done, pass, err_cnt, fail_vec} !== 21'd0) begin
      errors++;
      $display("FAIL arst_vals got %h want 0", {a, b, c, vec_idx, busy, done, pass, err_cnt, fail_vec});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL arst_needs_start bad_cycles %0d want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_or_model();
    test_stuck0();
    test_and_model();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
